// File: rtl/sprite_scheduler.sv
// sprite_scheduler: hands queued sprite draw commands to a pool of renderer
// slots in round-robin order, walks each slot through start/draw/release, and
// raises frame_done once a frame's sprites have all been drawn.
module sprite_scheduler #(
    parameter int NUM_RENDER = 2,
    parameter int ID_W       = 8,
    parameter int COORD_W    = 16,
    parameter int SCALE_W    = 8
) (
    input  logic                          clock,
    input  logic                          fb_resetting,
    input  logic                          q_empty,
    input  logic [ID_W-1:0]               q_id,
    input  logic [COORD_W-1:0]            q_x,
    input  logic [COORD_W-1:0]            q_y,
    input  logic [SCALE_W-1:0]            q_scale,
    output logic                          q_dequeue,
    input  logic                          frame_end,
    output logic [NUM_RENDER-1:0]         r_start,
    output logic [NUM_RENDER-1:0]         r_rst,
    output logic [NUM_RENDER*ID_W-1:0]    r_id,
    output logic [NUM_RENDER*COORD_W-1:0] r_x,
    output logic [NUM_RENDER*COORD_W-1:0] r_y,
    output logic [NUM_RENDER*SCALE_W-1:0] r_scale,
    output logic [NUM_RENDER-1:0]         r_en,
    input  logic [NUM_RENDER-1:0]         r_finished,
    output logic                          frame_done,
    output logic [15:0]                   sprite_count
);

    localparam int PTR_W = (NUM_RENDER > 1) ? $clog2(NUM_RENDER) : 1;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_BUSY    = 2'd1,
        SLOT_RELEASE = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        G_RUN   = 2'd0,
        G_DRAIN = 2'd1,
        G_DONE  = 2'd2
    } glob_state_t;

    slot_state_t      slot_state [NUM_RENDER];
    glob_state_t      glob_state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick;
    logic             any_idle;
    logic             all_idle;
    logic             dispatch;
    logic             drain_done;

    // Saturating increment so the count sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin pick: the idle slot with the smallest modular distance from rr_ptr.
    always_comb begin
        int off;
        int best_off;
        any_idle = 1'b0;
        all_idle = 1'b1;
        pick     = '0;
        off      = 0;
        best_off = NUM_RENDER;
        for (int j = 0; j < NUM_RENDER; j++) begin
            off = j - int'(rr_ptr);
            if (off < 0) off = off + NUM_RENDER;
            if (slot_state[j] != SLOT_IDLE) begin
                all_idle = 1'b0;
            end else if (off < best_off) begin
                best_off = off;
                pick     = PTR_W'(j);
            end
        end
        any_idle = (best_off < NUM_RENDER);
    end

    // A pop is blocked in the cycle q_dequeue is high so the queue head can advance first.
    assign dispatch   = !q_empty && !q_dequeue && any_idle && (glob_state != G_DONE);
    assign drain_done = (glob_state == G_DRAIN) && q_empty && all_idle && !dispatch && !q_dequeue;

    // Per-slot sequencing and command latching; r_en/r_rst mirror BUSY/RELEASE as registers.
    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            for (int k = 0; k < NUM_RENDER; k++) begin
                slot_state[k] <= SLOT_IDLE;
            end
            r_start <= '0;
            r_rst   <= '0;
            r_en    <= '0;
            r_id    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_scale <= '0;
        end else begin
            r_start <= '0;
            for (int k = 0; k < NUM_RENDER; k++) begin
                case (slot_state[k])
                    SLOT_IDLE: begin
                        // r_finished is deliberately ignored here.
                        if (dispatch && (pick == PTR_W'(k))) begin
                            slot_state[k]                <= SLOT_BUSY;
                            r_en[k]                      <= 1'b1;
                            r_start[k]                   <= 1'b1;
                            r_id[k*ID_W +: ID_W]         <= q_id;
                            r_x[k*COORD_W +: COORD_W]    <= q_x;
                            r_y[k*COORD_W +: COORD_W]    <= q_y;
                            r_scale[k*SCALE_W +: SCALE_W] <= q_scale;
                        end
                    end
                    SLOT_BUSY: begin
                        if (r_finished[k]) begin
                            slot_state[k] <= SLOT_RELEASE;
                            r_en[k]       <= 1'b0;
                            r_rst[k]      <= 1'b1;
                        end
                    end
                    SLOT_RELEASE: begin
                        slot_state[k] <= SLOT_IDLE;
                        r_rst[k]      <= 1'b0;
                    end
                    default: begin
                        slot_state[k] <= SLOT_IDLE;
                        r_en[k]       <= 1'b0;
                        r_rst[k]      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pop pulse, round-robin pointer, dispatch counter and frame-completion FSM.
    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            glob_state   <= G_RUN;
            rr_ptr       <= '0;
            q_dequeue    <= 1'b0;
            sprite_count <= '0;
            frame_done   <= 1'b0;
        end else begin
            q_dequeue <= dispatch;
            if (dispatch) begin
                if (int'(pick) == NUM_RENDER - 1) rr_ptr <= '0;
                else                              rr_ptr <= pick + 1'b1;
                sprite_count <= sat_inc16(sprite_count);
            end
            case (glob_state)
                G_RUN: begin
                    if (frame_end) glob_state <= G_DRAIN;
                end
                G_DRAIN: begin
                    if (drain_done) begin
                        glob_state <= G_DONE;
                        frame_done <= 1'b1;
                    end
                end
                G_DONE: begin
                    frame_done <= 1'b1;
                end
                default: begin
                    glob_state <= G_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Testbench for sprite_scheduler: a sprite queue model and renderer model
// drive the DUT; directed scenarios push hand-computed dispatch expectations
// into a scoreboard that a negedge monitor pops whenever r_start fires.
module tb_sprite_scheduler;

    logic        clock;
    logic        fb_resetting;
    logic        q_empty;
    logic [7:0]  q_id;
    logic [15:0] q_x;
    logic [15:0] q_y;
    logic [7:0]  q_scale;
    logic        q_dequeue;
    logic        frame_end;
    logic [1:0]  r_start;
    logic [1:0]  r_rst;
    logic [15:0] r_id;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [15:0] r_scale;
    logic [1:0]  r_en;
    logic [1:0]  r_finished;
    logic        frame_done;
    logic [15:0] sprite_count;

    sprite_scheduler #(
        .NUM_RENDER(2), .ID_W(8), .COORD_W(16), .SCALE_W(8)
    ) dut (
        .clock(clock), .fb_resetting(fb_resetting),
        .q_empty(q_empty), .q_id(q_id), .q_x(q_x), .q_y(q_y), .q_scale(q_scale),
        .q_dequeue(q_dequeue), .frame_end(frame_end),
        .r_start(r_start), .r_rst(r_rst),
        .r_id(r_id), .r_x(r_x), .r_y(r_y), .r_scale(r_scale),
        .r_en(r_en), .r_finished(r_finished),
        .frame_done(frame_done), .sprite_count(sprite_count)
    );

    typedef struct {
        int          slot;
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  sc;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Sprite queue storage: written by stimulus, read pointer advanced by the environment.
    logic [7:0]  spr_id [64];
    logic [15:0] spr_x  [64];
    logic [15:0] spr_y  [64];
    logic [7:0]  spr_sc [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign q_empty = (rd_ptr == wr_ptr);
    assign q_id    = spr_id[rd_ptr[5:0]];
    assign q_x     = spr_x[rd_ptr[5:0]];
    assign q_y     = spr_y[rd_ptr[5:0]];
    assign q_scale = spr_sc[rd_ptr[5:0]];

    exp_t       exp_q[$];
    exp_t       e;
    int         deq_count = 0;
    int         deq_base  = 0;
    logic       deq_prev  = 1'b0;
    int         fin_delay = 0;
    logic [1:0] man_req   = 2'b00;
    int         cnt [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Environment: pops the queue and models renderers, acting just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (fb_resetting) begin
            r_finished = 2'b00;
            cnt[0] = 0;
            cnt[1] = 0;
        end else begin
            if (q_dequeue && (rd_ptr != wr_ptr)) rd_ptr = rd_ptr + 1;
            for (int k = 0; k < 2; k++) begin
                if (r_rst[k]) begin
                    r_finished[k] = 1'b0;
                end else if (r_start[k]) begin
                    cnt[k] = fin_delay;
                end else if (man_req[k] && r_en[k]) begin
                    r_finished[k] = 1'b1;
                end else if (r_en[k] && cnt[k] > 0) begin
                    cnt[k] = cnt[k] - 1;
                    if (cnt[k] == 0) r_finished[k] = 1'b1;
                end
            end
        end
    end

    // Monitor: scoreboard comparison on every r_start, plus dequeue spacing.
    always @(negedge clock) begin
        if (fb_resetting) begin
            deq_prev = 1'b0;
        end else begin
            if (q_dequeue) begin
                check("deq_not_back_to_back", {63'd0, deq_prev}, 64'd0);
                deq_count = deq_count + 1;
            end
            deq_prev = q_dequeue;
            if (r_start != 2'b00) begin
                check("dequeue_with_start", {63'd0, q_dequeue}, 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_dispatch", {62'd0, r_start}, 64'd0);
                end else begin
                    logic [1:0] want;
                    e    = exp_q.pop_front();
                    want = 2'(1 << e.slot);
                    check("start_slot", {62'd0, r_start}, {62'd0, want});
                    check("start_id", {56'd0, r_id[e.slot*8 +: 8]}, {56'd0, e.id});
                    check("start_x", {48'd0, r_x[e.slot*16 +: 16]}, {48'd0, e.x});
                    check("start_y", {48'd0, r_y[e.slot*16 +: 16]}, {48'd0, e.y});
                    check("start_scale", {56'd0, r_scale[e.slot*8 +: 8]}, {56'd0, e.sc});
                    check("start_count", {48'd0, sprite_count}, {48'd0, e.cnt});
                    if (e.cyc >= 0) check("start_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic add_sprite(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                              input logic [7:0] sc, output int idx);
        idx = wr_ptr;
        spr_id[wr_ptr[5:0]] = id;
        spr_x[wr_ptr[5:0]]  = x;
        spr_y[wr_ptr[5:0]]  = y;
        spr_sc[wr_ptr[5:0]] = sc;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_disp(input int slot, input int idx, input logic [15:0] c, input int at);
        exp_t t;
        t.slot = slot;
        t.id   = spr_id[idx[5:0]];
        t.x    = spr_x[idx[5:0]];
        t.y    = spr_y[idx[5:0]];
        t.sc   = spr_sc[idx[5:0]];
        t.cnt  = c;
        t.cyc  = at;
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clock);
        fb_resetting = 1'b1;
        frame_end    = 1'b0;
        man_req      = 2'b00;
        exp_q.delete();
        repeat (3) @(negedge clock);
        wr_ptr = rd_ptr;
    endtask

    task automatic release_reset(output int c);
        @(negedge clock);
        fb_resetting = 1'b0;
        c = cyc;
        deq_base = deq_count;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int ia, ib, ic, i4;
        int idx8 [8];

        fb_resetting = 1'b1;
        frame_end    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_q_dequeue", {63'd0, q_dequeue}, 64'd0);
        check("rst_r_start", {62'd0, r_start}, 64'd0);
        check("rst_r_en", {62'd0, r_en}, 64'd0);
        check("rst_r_rst", {62'd0, r_rst}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_sprite_count", {48'd0, sprite_count}, 64'd0);
        check("rst_r_id", {48'd0, r_id}, 64'd0);

        // Two dispatches into two held slots, third sprite waits; then slot 0 releases.
        do_reset();
        fin_delay = 0;
        release_reset(c);
        add_sprite(8'h11, 16'd100, 16'd200, 8'd3, ia);
        add_sprite(8'h22, 16'd300, 16'd400, 8'd5, ib);
        add_sprite(8'h33, 16'd500, 16'd600, 8'd7, ic);
        expect_disp(0, ia, 16'd1, c + 1);
        expect_disp(1, ib, 16'd2, c + 3);
        wait_cyc(c + 9);
        check("t1_sprite_count", {48'd0, sprite_count}, 64'd2);
        check("t1_deq_pulses", 64'(deq_count - deq_base), 64'd2);
        check("t1_r_en", {62'd0, r_en}, 64'd3);
        man_req = 2'b01;
        expect_disp(0, ic, 16'd3, c + 13);
        wait_cyc(c + 10);
        man_req = 2'b00;
        wait_cyc(c + 11);
        check("t2_r_rst_pulse", {62'd0, r_rst}, 64'd1);
        check("t2_r_en_release", {62'd0, r_en}, 64'd2);
        wait_cyc(c + 12);
        check("t2_r_rst_clear", {62'd0, r_rst}, 64'd0);
        wait_cyc(c + 16);
        check("t2_r_en_both", {62'd0, r_en}, 64'd3);
        check("t2_slot1_id", {48'd0, r_id[15:8]}, 64'h22);
        check("t2_slot1_x", {48'd0, r_x[31:16]}, 64'd300);
        check("t2_slot1_y", {48'd0, r_y[31:16]}, 64'd400);
        check("t2_slot1_scale", {56'd0, r_scale[15:8]}, 64'd5);
        check("t2_sb_drained", 64'(exp_q.size()), 64'd0);

        // Back-to-back 8 sprites with renderers finishing 5 cycles after start.
        do_reset();
        fin_delay = 5;
        release_reset(c);
        for (int i = 0; i < 8; i++) begin
            add_sprite(8'(8'h40 + i), 16'(16'h1000 + i), 16'(16'h2000 + i), 8'(i + 1), idx8[i]);
            expect_disp(i % 2, idx8[i], 16'(i + 1), c + (i / 2) * 8 + 1 + (i % 2) * 2);
        end
        wait_cyc(c + 40);
        check("t3_sprite_count", {48'd0, sprite_count}, 64'd8);
        check("t3_deq_pulses", 64'(deq_count - deq_base), 64'd8);
        check("t3_r_en_idle", {62'd0, r_en}, 64'd0);
        check("t3_sb_drained", 64'(exp_q.size()), 64'd0);

        // frame_end with 2 queued: both dispatched, frame_done after last slot idles.
        do_reset();
        fin_delay = 5;
        release_reset(c);
        frame_end = 1'b1;
        add_sprite(8'h51, 16'd11, 16'd12, 8'd2, ia);
        add_sprite(8'h52, 16'd21, 16'd22, 8'd4, ib);
        expect_disp(0, ia, 16'd1, c + 1);
        expect_disp(1, ib, 16'd2, c + 3);
        @(negedge clock);
        frame_end = 1'b0;
        wait_cyc(c + 10);
        check("t4_frame_done_early", {63'd0, frame_done}, 64'd0);
        check("t4_r_en_idle", {62'd0, r_en}, 64'd0);
        wait_cyc(c + 11);
        check("t4_frame_done_rise", {63'd0, frame_done}, 64'd1);
        wait_cyc(c + 12);
        add_sprite(8'h5F, 16'd1, 16'd1, 8'd1, ic);
        wait_cyc(c + 22);
        check("t4_frame_done_hold", {63'd0, frame_done}, 64'd1);
        check("t4_no_dispatch_done", 64'(deq_count - deq_base), 64'd2);
        check("t4_sprite_count", {48'd0, sprite_count}, 64'd2);

        // Asynchronous reset while both slots are busy with rr_ptr at 1.
        do_reset();
        fin_delay = 0;
        release_reset(c);
        add_sprite(8'h61, 16'd31, 16'd32, 8'd6, ia);
        add_sprite(8'h62, 16'd41, 16'd42, 8'd8, ib);
        add_sprite(8'h63, 16'd51, 16'd52, 8'd9, ic);
        add_sprite(8'h64, 16'd61, 16'd62, 8'd10, i4);
        expect_disp(0, ia, 16'd1, c + 1);
        expect_disp(1, ib, 16'd2, c + 3);
        expect_disp(0, ic, 16'd3, c + 8);
        wait_cyc(c + 4);
        man_req = 2'b01;
        wait_cyc(c + 5);
        man_req = 2'b00;
        wait_cyc(c + 10);
        check("t5_both_busy", {62'd0, r_en}, 64'd3);
        #2;
        fb_resetting = 1'b1;
        #1;
        check("t5_async_r_en", {62'd0, r_en}, 64'd0);
        check("t5_async_count", {48'd0, sprite_count}, 64'd0);
        check("t5_async_r_id", {48'd0, r_id}, 64'd0);
        check("t5_async_r_x", {32'd0, r_x}, 64'd0);
        check("t5_sb_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        release_reset(c);
        expect_disp(0, i4, 16'd1, c + 1);
        wait_cyc(c + 4);
        check("t5_first_slot0", {62'd0, r_en}, 64'd1);
        check("t5_sb_drained2", 64'(exp_q.size()), 64'd0);

        // Saturation of sprite_count, starting just below the ceiling.
        do_reset();
        fin_delay = 5;
        release_reset(c);
        force dut.sprite_count = 16'hFFFD;
        #1;
        release dut.sprite_count;
        add_sprite(8'h71, 16'd1, 16'd2, 8'd1, ia);
        add_sprite(8'h72, 16'd3, 16'd4, 8'd2, ib);
        add_sprite(8'h73, 16'd5, 16'd6, 8'd3, ic);
        expect_disp(0, ia, 16'hFFFE, c + 1);
        expect_disp(1, ib, 16'hFFFF, c + 3);
        expect_disp(0, ic, 16'hFFFF, c + 9);
        wait_cyc(c + 14);
        check("t6_saturated", {48'd0, sprite_count}, 64'hFFFF);
        check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Dispatches sprite draw commands from the sprite draw queue to a pool of `NUM_RENDER` sprite renderers and sequences each renderer through start, draw and release. It sits between the sprite queue and the renderer instances inside the sprite driver, replacing ad-hoc distribution logic. It also tracks end-of-frame completion so the frame swap logic knows when all sprites for a frame have been drawn.

## Interface
- `NUM_RENDER`, 2: number of renderer slots (1..4).
- `ID_W`, 8: sprite id width.
- `COORD_W`, 16: x/y coordinate width.
- `SCALE_W`, 8: scale width.
- `clock`  in  1  system clock, all logic on rising edge.
- `fb_resetting`  in  1  reset, asynchronous, active-high; clock clock. Held high while the framebuffer clears.
- `q_empty`  in  1  queue empty; head fields valid when 0.
- `q_id` / `q_x` / `q_y` / `q_scale`  in  ID_W / COORD_W / COORD_W / SCALE_W  queue head fields.
- `q_dequeue`  out  1  one-cycle pop pulse.
- `frame_end`  in  1  one-cycle pulse: last sprite of the frame has been enqueued.
- `r_start`  out  NUM_RENDER  per-slot one-cycle start pulse.
- `r_rst`  out  NUM_RENDER  per-slot one-cycle renderer reset pulse.
- `r_id` / `r_x` / `r_y` / `r_scale`  out  NUM_RENDER×field width (slot k at bits [k*W +: W])  per-slot held command fields.
- `r_en`  out  NUM_RENDER  per-slot enable, high from start until release.
- `r_finished`  in  NUM_RENDER  per-slot level, high once the renderer completes, stays high until `r_rst`.
- `frame_done`  out  1  high when the frame is fully drawn, held until reset.
- `sprite_count`  out  16  sprites dispatched since reset, saturating at 0xFFFF.

## Operation
- Per-slot FSM: IDLE → BUSY (dispatch) → RELEASE (when `r_finished` high in BUSY) → IDLE (unconditionally, after 1 cycle).
- In BUSY: `r_en`=1. RELEASE: `r_en`=0 and `r_rst`=1.
- Dispatch condition in a cycle: `q_empty`=0, `q_dequeue` was not asserted in the previous cycle, and at least one slot is IDLE.
- At most one dispatch per cycle.
- Slot choice is round-robin. Search starts at `rr_ptr` and takes the first IDLE slot in ascending modular order. After a dispatch to slot k, `rr_ptr` = (k+1) mod NUM_RENDER. `rr_ptr` resets to 0.
- On dispatch to slot k, at the clock edge:
  - Queue head fields are latched into slot k's outputs; they hold until the next dispatch to slot k.
  - `r_start[k]`=1 and `q_dequeue`=1 for one cycle.
  - `sprite_count` increments.
- Global FSM:
  - RUN: default state.
  - RUN → DRAIN on `frame_end`.
  - DRAIN → DONE when `q_empty`=1, all slots IDLE, and no dispatch or `q_dequeue` is in flight.
  - DONE: `frame_done`=1 and no further dispatches; the queue is ignored.
- Dispatching continues normally in DRAIN.
- `frame_end` received in DRAIN or DONE is ignored.
- `r_finished` is ignored in IDLE and RELEASE.
- `r_finished` high in the same cycle as a dispatch to slot k has no effect: that slot was IDLE.

## Timing
- Reset values: all outputs 0, all slots IDLE, global state RUN, `rr_ptr`=0, field registers 0.
- Asserting `fb_resetting` mid-frame aborts all slots immediately. No `r_rst` pulse is issued; renderers share the same reset.
- Dispatch latency: queue non-empty at cycle t (conditions met) → `r_start`, `q_dequeue` and fields visible at t+1.
- Next dispatch is possible at t+2 at the earliest.
- `r_finished` first sampled high at cycle t → `r_rst` high at t+1 → slot IDLE at t+2 → earliest new `r_start` on that slot at t+3.
- `frame_done` rises one cycle after the DRAIN→DONE condition holds.
- Simultaneous release of several slots is permitted; each slot's `r_rst` is independent.

## Test plan
- Reset release, queue holds 3 sprites, `r_finished` tied 0 → `r_start` pulses to slot 0 at cycle 1 and slot 1 at cycle 3 with correct fields. No third dispatch; `q_dequeue` pulses exactly twice; `sprite_count`=2.
- Slot 0 `r_finished` raised at cycle 10 with queue non-empty → `r_rst[0]` at 11, `r_start[0]` at 13. Field outputs for slot 1 unchanged throughout.
- Back-to-back 8 sprites, renderers finishing after 5 cycles → dispatch order alternates 0,1,0,1…. `q_dequeue` is never high on two consecutive cycles; `sprite_count`=8.
- `frame_end` pulse with 2 sprites still queued → all 2 dispatched. `frame_done` rises exactly 1 cycle after the last slot returns to IDLE with the queue empty; later enqueues are not dispatched.
- `fb_resetting` asserted while both slots BUSY → all outputs 0 asynchronously. After release, the first dispatch targets slot 0.
- `sprite_count` preloaded via long run of 65 540 dispatches → `sprite_count` saturates at 0xFFFF.
